// File: rtl/param_fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO and its storage array.
package param_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 6;
    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int DEFAULT_TH_WIDTH   = 4;
    localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

    // Number of words addressable by a pointer of the given width.
    function automatic int fifo_depth(input int addr_width);
        return 2 ** addr_width;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Simple dual-port register array: one write port and one registered read port.
// No reset: contents are meaningless until written, and the FIFO control logic
// never reads a location it has not written since the last reset.
module fifo_mem_dp
    import param_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Write the incoming word and capture the addressed word on a read; a read of
    // the slot being written in the same cycle returns the old contents.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with occupancy, programmable almost-full and
// almost-empty thresholds, a read-valid strobe and sticky overflow/underflow errors.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int TH_WIDTH   = DEFAULT_TH_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_init,
    input  logic                  i_wr_enable,
    input  logic                  i_rd_enable,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic [TH_WIDTH-1:0]   i_umbral_full,
    input  logic [TH_WIDTH-1:0]   i_umbral_empty,
    input  logic                  i_clr_error,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_valid_out,
    output logic                  o_full_fifo,
    output logic                  o_empty_fifo,
    output logic                  o_almost_full_fifo,
    output logic                  o_almost_empty_fifo,
    output logic [ADDR_WIDTH:0]   o_occupancy,
    output logic                  o_overflow_err,
    output logic                  o_underflow_err
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    // Threshold sums are formed wide enough that a threshold above DEPTH saturates
    // the comparison instead of wrapping.
    localparam int SW = ADDR_WIDTH + TH_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [SW-1:0]       DEPTH_S = SW'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_run;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic [DATA_WIDTH-1:0] w_mem_q;
    logic [SW-1:0]         w_af_sum;

    assign w_run    = i_reset & i_init;
    assign w_full   = (r_cnt == DEPTH_C);
    assign w_empty  = (r_cnt == '0);
    // A read on a full FIFO frees a slot, so a simultaneous write is still taken.
    assign w_rd_acc = i_rd_enable & ~w_empty;
    assign w_wr_acc = i_wr_enable & (~w_full | w_rd_acc);
    assign w_af_sum = SW'(r_cnt) + SW'(i_umbral_full);

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_acc & w_run),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_data_in),
        .i_rd_en   (w_rd_acc & w_run),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_q)
    );

    // Advance pointers on accepted transfers and track occupancy; reset or init
    // discards everything in the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset || !i_init) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            r_valid <= w_rd_acc;
        end
    end

    // Sticky error capture; a new error event takes priority over a clear.
    always_ff @(posedge i_clk) begin
        if (!i_reset || !i_init) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr_enable && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (i_clr_error) begin
                r_overflow <= 1'b0;
            end
            if (i_rd_enable && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (i_clr_error) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Status flags follow count and thresholds immediately, forced idle during reset/init.
    always_comb begin
        o_full_fifo         = 1'b0;
        o_empty_fifo        = 1'b1;
        o_almost_full_fifo  = 1'b0;
        o_almost_empty_fifo = 1'b0;
        o_occupancy         = '0;
        if (w_run) begin
            o_full_fifo         = w_full;
            o_empty_fifo        = w_empty;
            o_almost_full_fifo  = (w_af_sum >= DEPTH_S) && (r_cnt < DEPTH_C);
            o_almost_empty_fifo = !w_empty && (SW'(r_cnt) <= SW'(i_umbral_empty));
            o_occupancy         = r_cnt;
        end
    end

    // The read port holds its last word, so data is only presented alongside valid.
    assign o_data_out      = r_valid ? w_mem_q : '0;
    assign o_valid_out     = r_valid;
    assign o_overflow_err  = r_overflow;
    assign o_underflow_err = r_underflow;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: a reference queue models contents, and
// expected read data is queued when a read is accepted and popped when valid_out rises.
module tb_param_fifo;

    localparam int DW    = 6;
    localparam int AW    = 3;
    localparam int TW    = 4;
    localparam int DEPTH = 8;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_init = 1'b1;
    logic          i_wr_enable = 1'b0;
    logic          i_rd_enable = 1'b0;
    logic [DW-1:0] i_data_in = '0;
    logic [TW-1:0] i_umbral_full = '0;
    logic [TW-1:0] i_umbral_empty = '0;
    logic          i_clr_error = 1'b0;
    logic [DW-1:0] o_data_out;
    logic          o_valid_out;
    logic          o_full_fifo;
    logic          o_empty_fifo;
    logic          o_almost_full_fifo;
    logic          o_almost_empty_fifo;
    logic [AW:0]   o_occupancy;
    logic          o_overflow_err;
    logic          o_underflow_err;

    int testsRun = 0;
    int testsFailed = 0;

    logic [DW-1:0] modelQ[$];
    logic [DW-1:0] expQ[$];
    logic          expValid = 1'b0;
    logic          mOvf = 1'b0;
    logic          mUnf = 1'b0;
    logic [DW-1:0] expData;

    param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TH_WIDTH(TW)) dut (
        .i_clk               (i_clk),
        .i_reset             (i_reset),
        .i_init              (i_init),
        .i_wr_enable         (i_wr_enable),
        .i_rd_enable         (i_rd_enable),
        .i_data_in           (i_data_in),
        .i_umbral_full       (i_umbral_full),
        .i_umbral_empty      (i_umbral_empty),
        .i_clr_error         (i_clr_error),
        .o_data_out          (o_data_out),
        .o_valid_out         (o_valid_out),
        .o_full_fifo         (o_full_fifo),
        .o_empty_fifo        (o_empty_fifo),
        .o_almost_full_fifo  (o_almost_full_fifo),
        .o_almost_empty_fifo (o_almost_empty_fifo),
        .o_occupancy         (o_occupancy),
        .o_overflow_err      (o_overflow_err),
        .o_underflow_err     (o_underflow_err)
    );

    // Free-running 10-unit clock.
    always #5 i_clk = ~i_clk;

    // Drive one cycle of requests, update the reference model from pre-edge state,
    // then let the edge pass and settle 1 unit past it.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [DW-1:0] d);
        logic rdAcc;
        logic wrAcc;
        i_wr_enable = wr;
        i_rd_enable = rd;
        i_data_in   = d;
        if (!i_reset || !i_init) begin
            modelQ.delete();
            expQ.delete();
            expValid = 1'b0;
            mOvf = 1'b0;
            mUnf = 1'b0;
        end else begin
            rdAcc = rd && (modelQ.size() > 0);
            wrAcc = wr && ((modelQ.size() < DEPTH) || rdAcc);
            if (rdAcc) expQ.push_back(modelQ.pop_front());
            if (wrAcc) modelQ.push_back(d);
            if (wr && !wrAcc) mOvf = 1'b1;
            else if (i_clr_error) mOvf = 1'b0;
            if (rd && !rdAcc) mUnf = 1'b1;
            else if (i_clr_error) mUnf = 1'b0;
            expValid = rdAcc;
        end
        @(posedge i_clk);
        #1;
        i_wr_enable = 1'b0;
        i_rd_enable = 1'b0;
        i_clr_error = 1'b0;
    endtask

    task automatic test_reset();
        i_umbral_full  = 4'd9;
        i_umbral_empty = 4'd3;
        i_reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 6'h15);
        applyStimulus(1'b1, 1'b0, 6'h15);
        testsRun++; if (o_empty_fifo !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_empty: got %b expected 1", o_empty_fifo); end
        testsRun++; if (o_full_fifo !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_full: got %b expected 0", o_full_fifo); end
        testsRun++; if (o_occupancy !== 4'd0) begin testsFailed++; $display("[TB] FAIL reset_occ: got %0d expected 0", o_occupancy); end
        testsRun++; if (o_valid_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid_out); end
        testsRun++; if ({o_overflow_err, o_underflow_err} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_errs: got %b expected 00", {o_overflow_err, o_underflow_err}); end
        testsRun++; if ({o_almost_full_fifo, o_almost_empty_fifo} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_almost: got %b expected 00", {o_almost_full_fifo, o_almost_empty_fifo}); end
        i_reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'h00);
        testsRun++; if (o_empty_fifo !== 1'b1) begin testsFailed++; $display("[TB] FAIL post_reset_empty: got %b expected 1", o_empty_fifo); end
        testsRun++; if (o_occupancy !== 4'd0) begin testsFailed++; $display("[TB] FAIL post_reset_occ: got %0d expected 0", o_occupancy); end
    endtask

    task automatic test_fill_overflow();
        logic expAf;
        i_umbral_full  = 4'd2;
        i_umbral_empty = 4'd0;
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 6'(i));
            expAf = (i >= DEPTH - 2) && (i < DEPTH);
            testsRun++; if (o_occupancy !== 4'(i)) begin testsFailed++; $display("[TB] FAIL fill_occ: got %0d expected %0d", o_occupancy, i); end
            testsRun++; if (o_almost_full_fifo !== expAf) begin testsFailed++; $display("[TB] FAIL fill_af at %0d: got %b expected %b", i, o_almost_full_fifo, expAf); end
            testsRun++; if (o_full_fifo !== (i == DEPTH)) begin testsFailed++; $display("[TB] FAIL fill_full at %0d: got %b", i, o_full_fifo); end
        end
        applyStimulus(1'b1, 1'b0, 6'h09);
        testsRun++; if (o_overflow_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL overflow_set: got %b expected 1", o_overflow_err); end
        testsRun++; if (o_occupancy !== 4'd8) begin testsFailed++; $display("[TB] FAIL overflow_occ: got %0d expected 8", o_occupancy); end
        applyStimulus(1'b0, 1'b1, 6'h00);
        testsRun++; if (o_valid_out !== expValid) begin testsFailed++; $display("[TB] FAIL ovf_read_valid: got %b expected %b", o_valid_out, expValid); end
        if (expValid) begin
            expData = expQ.pop_front();
            testsRun++; if (o_data_out !== expData) begin testsFailed++; $display("[TB] FAIL ovf_read_data: got %h expected %h", o_data_out, expData); end
        end
        testsRun++; if (o_data_out !== 6'h01) begin testsFailed++; $display("[TB] FAIL ovf_read_first: got %h expected 01", o_data_out); end
    endtask

    task automatic test_full_simultaneous();
        logic [DW-1:0] lastOut;
        lastOut = '0;
        i_reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 6'h00);
        i_reset = 1'b1;
        for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 1'b0, 6'(i));
        applyStimulus(1'b1, 1'b1, 6'h2A);
        testsRun++; if (o_occupancy !== 4'd8) begin testsFailed++; $display("[TB] FAIL fullsim_occ: got %0d expected 8", o_occupancy); end
        testsRun++; if (o_valid_out !== 1'b1) begin testsFailed++; $display("[TB] FAIL fullsim_valid: got %b expected 1", o_valid_out); end
        testsRun++; if (o_data_out !== 6'h01) begin testsFailed++; $display("[TB] FAIL fullsim_data: got %h expected 01", o_data_out); end
        testsRun++; if (o_overflow_err !== mOvf) begin testsFailed++; $display("[TB] FAIL fullsim_ovf: got %b expected %b", o_overflow_err, mOvf); end
        if (expValid) void'(expQ.pop_front());
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 6'h00);
            testsRun++; if (o_valid_out !== expValid) begin testsFailed++; $display("[TB] FAIL drain_valid: got %b expected %b", o_valid_out, expValid); end
            if (expValid) begin
                expData = expQ.pop_front();
                testsRun++; if (o_data_out !== expData) begin testsFailed++; $display("[TB] FAIL drain_data: got %h expected %h", o_data_out, expData); end
            end
            lastOut = o_data_out;
        end
        testsRun++; if (lastOut !== 6'h2A) begin testsFailed++; $display("[TB] FAIL drain_last: got %h expected 2a", lastOut); end
        testsRun++; if (o_empty_fifo !== 1'b1) begin testsFailed++; $display("[TB] FAIL drain_empty: got %b expected 1", o_empty_fifo); end
    endtask

    task automatic test_empty_simultaneous();
        applyStimulus(1'b1, 1'b1, 6'h0F);
        testsRun++; if (o_underflow_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL emptysim_unf: got %b expected 1", o_underflow_err); end
        testsRun++; if (o_valid_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL emptysim_valid: got %b expected 0", o_valid_out); end
        testsRun++; if (o_data_out !== 6'h00) begin testsFailed++; $display("[TB] FAIL emptysim_data: got %h expected 00", o_data_out); end
        testsRun++; if (o_occupancy !== 4'd1) begin testsFailed++; $display("[TB] FAIL emptysim_occ: got %0d expected 1", o_occupancy); end
        applyStimulus(1'b0, 1'b1, 6'h00);
        testsRun++; if (o_valid_out !== 1'b1) begin testsFailed++; $display("[TB] FAIL emptysim_rd_valid: got %b expected 1", o_valid_out); end
        if (expValid) begin
            expData = expQ.pop_front();
            testsRun++; if (o_data_out !== expData) begin testsFailed++; $display("[TB] FAIL emptysim_rd_data: got %h expected %h", o_data_out, expData); end
        end
    endtask

    task automatic test_wrap_thresholds();
        int occ;
        logic expAe;
        i_umbral_empty = 4'd3;
        i_umbral_full  = 4'd9;
        for (int c = 0; c < 28; c++) begin
            applyStimulus(c < 20, c >= 8, 6'(c * 3 + 5));
            occ = modelQ.size();
            expAe = (occ >= 1) && (occ <= 3);
            testsRun++; if (o_occupancy !== 4'(occ)) begin testsFailed++; $display("[TB] FAIL wrap_occ c=%0d: got %0d expected %0d", c, o_occupancy, occ); end
            testsRun++; if (o_almost_empty_fifo !== expAe) begin testsFailed++; $display("[TB] FAIL wrap_ae c=%0d: got %b expected %b", c, o_almost_empty_fifo, expAe); end
            if (occ != 0) begin
                testsRun++; if (o_almost_full_fifo !== (occ < DEPTH)) begin testsFailed++; $display("[TB] FAIL wrap_af c=%0d: got %b occ %0d", c, o_almost_full_fifo, occ); end
            end
            testsRun++; if (o_valid_out !== expValid) begin testsFailed++; $display("[TB] FAIL wrap_valid c=%0d: got %b expected %b", c, o_valid_out, expValid); end
            if (expValid) begin
                expData = expQ.pop_front();
                testsRun++; if (o_data_out !== expData) begin testsFailed++; $display("[TB] FAIL wrap_data c=%0d: got %h expected %h", c, o_data_out, expData); end
            end
        end
    endtask

    task automatic test_clear_init();
        testsRun++; if (o_underflow_err !== mUnf) begin testsFailed++; $display("[TB] FAIL clr_pre_unf: got %b expected %b", o_underflow_err, mUnf); end
        i_clr_error = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'h00);
        testsRun++; if ({o_overflow_err, o_underflow_err} !== 2'b00) begin testsFailed++; $display("[TB] FAIL clr_errs: got %b expected 00", {o_overflow_err, o_underflow_err}); end
        i_clr_error = 1'b1;
        applyStimulus(1'b0, 1'b1, 6'h00);
        testsRun++; if (o_underflow_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL clr_set_wins: got %b expected 1", o_underflow_err); end
        i_clr_error = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'h00);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 6'(i + 40));
        testsRun++; if (o_occupancy !== 4'd5) begin testsFailed++; $display("[TB] FAIL init_pre_occ: got %0d expected 5", o_occupancy); end
        i_init = 1'b0;
        applyStimulus(1'b1, 1'b0, 6'h3F);
        i_init = 1'b1;
        #1;
        testsRun++; if (o_occupancy !== 4'd0) begin testsFailed++; $display("[TB] FAIL init_occ: got %0d expected 0", o_occupancy); end
        testsRun++; if (o_empty_fifo !== 1'b1) begin testsFailed++; $display("[TB] FAIL init_empty: got %b expected 1", o_empty_fifo); end
        testsRun++; if (o_valid_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL init_valid: got %b expected 0", o_valid_out); end
        applyStimulus(1'b1, 1'b0, 6'h11);
        applyStimulus(1'b0, 1'b1, 6'h00);
        if (expValid) begin
            expData = expQ.pop_front();
            testsRun++; if (o_data_out !== expData) begin testsFailed++; $display("[TB] FAIL init_fresh_data: got %h expected %h", o_data_out, expData); end
        end
        testsRun++; if (o_data_out !== 6'h11) begin testsFailed++; $display("[TB] FAIL init_fresh_literal: got %h expected 11", o_data_out); end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill_overflow();
        test_full_simultaneous();
        test_empty_simultaneous();
        test_wrap_thresholds();
        test_clear_init();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous FIFO, the next-generation replacement for the per-lane main FIFO in the PCIe transmit-layer datapath. It adds separate almost-full and almost-empty thresholds, an occupancy output and a read-valid strobe. Read and write may both be accepted on a full FIFO, and overflow and underflow are reported as separate sticky errors. It sits between the lane-mux stage and the virtual-channel FIFOs and also serves as the generic buffer for later stages.

Parameters:
DATA_WIDTH, 6, width of each stored word
ADDR_WIDTH, 3, pointer width; depth DEPTH = 2**ADDR_WIDTH (default 8)
TH_WIDTH, 4, width of the threshold inputs

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-low reset
init  input  1  synchronous, active-low soft init; same effect as reset
wr_enable  input  1  write request
rd_enable  input  1  read request
data_in  input  DATA_WIDTH  write data
umbral_full  input  TH_WIDTH  almost-full threshold
umbral_empty  input  TH_WIDTH  almost-empty threshold
clr_error  input  1  clears both sticky errors
data_out  output  DATA_WIDTH  registered read data
valid_out  output  1  data_out holds a word from an accepted read
full_fifo  output  1  cnt == DEPTH
empty_fifo  output  1  cnt == 0
almost_full_fifo  output  1  DEPTH-umbral_full <= cnt < DEPTH
almost_empty_fifo  output  1  0 < cnt <= umbral_empty
occupancy  output  ADDR_WIDTH+1  current cnt
overflow_err  output  1  sticky: a write was rejected
underflow_err  output  1  sticky: a read was rejected

Behaviour:
- Reset/init: the clock, reset polarity and synchronicity are fixed — one clock (clk); reset is synchronous and active-low.
- On a clk edge with reset==0 or init==0:
  - wr_ptr, rd_ptr, cnt, data_out, valid_out, overflow_err and underflow_err go to 0.
  - Memory contents are don't-care and need not be cleared.
- While reset==0 or init==0, flags are forced combinationally: full=0, empty=1, almost_full=0, almost_empty=0, occupancy=0.
- Accept rules, evaluated on pre-edge state:
  - rd_acc = rd_enable & ~empty.
  - wr_acc = wr_enable & (~full | rd_acc). On a full FIFO, a simultaneous read frees a slot, so the write is accepted and cnt holds at DEPTH.
  - Empty with both requests: the write is accepted, the read is rejected, and underflow_err is set. There is no fall-through.
- Pointers and count:
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally mod DEPTH.
  - cnt is ADDR_WIDTH+1 bits: +1 on wr_acc&~rd_acc, -1 on rd_acc&~wr_acc, unchanged otherwise.
  - cnt must never exceed DEPTH or underflow below 0.
- Read latency is 1 cycle:
  - On rd_acc, data_out <= mem[rd_ptr] and valid_out <= 1.
  - Otherwise data_out <= 0 and valid_out <= 0.
- Errors:
  - overflow_err <= 1 on wr_enable & ~wr_acc.
  - underflow_err <= 1 on rd_enable & ~rd_acc.
  - Both are sticky until clr_error or reset. If clr_error coincides with a new error event, the set wins.
- Flags are combinational from cnt and the thresholds:
  - almost_full compares cnt + umbral_full >= DEPTH in ADDR_WIDTH+TH_WIDTH+1 bits, so a threshold larger than DEPTH saturates without wrap.
  - umbral_empty == 0 gives almost_empty = 0.
  - umbral_full == 0 gives almost_full = 0.
  - Thresholds may change at any time; the flags follow them immediately.
- Reset or init asserted mid-operation discards all contents in the same edge, with no drain.

Decomposition:
- Shared package param_fifo_pkg holds:
  - Default constants DEFAULT_DATA_WIDTH=6, DEFAULT_ADDR_WIDTH=3, DEFAULT_TH_WIDTH=4.
  - Localparam DEPTH derivation.
- One sub-module, fifo_mem_dp: a simple dual-port register array (one write port, one registered read port, no reset).
- Pointer, count, flag and error logic stay in param_fifo.

Test Plan:
1. Reset hold: reset=0 for 2 cycles with wr_enable=1, data_in=6'h15 -> empty=1, full=0, occupancy=0, valid_out=0, errors=0. After release the FIFO is still empty.
2. Fill and overflow, umbral_full=2:
   - Write 6'h01..6'h08 -> almost_full at occupancy 6 and 7, then full=1 at 8.
   - A 9th write with no read -> overflow_err=1, occupancy stays 8, and a read returns 6'h01.
3. Full simultaneous: full, wr+rd of 6'h2A for 1 cycle -> occupancy stays 8, data_out=6'h01 with valid_out=1 one cycle later, overflow_err stays 0. After 8 reads the last word out is 6'h2A.
4. Empty simultaneous: empty, wr(6'h0F)+rd -> underflow_err=1, valid_out=0, occupancy=1. The next read returns 6'h0F.
5. Wrap and thresholds: umbral_empty=3, umbral_full=9 (>DEPTH); stream 20 writes/reads interleaved.
   - Data order is preserved across the pointer wrap.
   - almost_empty is high for occupancy 1..3.
   - almost_full is high for occupancy 0..7 except where empty overrides, and never at 8.
6. Error clear and init: pulse clr_error -> both errors drop to 0. Then init=0 for 1 cycle mid-stream with occupancy 5 -> occupancy=0 and empty=1 on the next cycle.
